// File: rtl/spi_adapter_mux.sv
// Multi-channel SPI minion adapter: routes SPI pushes/pulls to per-channel mc/cm circular queues.
// Writes show up on send one cycle after the push edge; a read is a request push followed by a pull.

module spi_adapter_mux_fifo #(
  parameter  int width = 8,
  parameter  int depth = 2,
  localparam int cw    = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic [width-1:0] enq_msg,
  output logic             deq_val,
  output logic [width-1:0] deq_msg,
  input  logic             deq_rdy,
  output logic [cw-1:0]    count
);
  localparam int pa = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [pa-1:0] last = pa'(depth - 1);
  localparam logic [cw-1:0] full = cw'(depth);

  logic [width-1:0] mem [depth];
  logic [pa-1:0]    rd_ptr;
  logic [pa-1:0]    wr_ptr;
  logic             enq;
  logic             deq;

  // Room is judged on the registered count only, so a full queue refuses
  // an enqueue even when it is being drained in the same cycle.
  assign enq     = enq_val & (count < full);
  assign deq     = deq_val & deq_rdy;
  assign deq_val = (count != '0);
  assign deq_msg = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == last) ? '0 : wr_ptr + pa'(1);
      if (deq) rd_ptr <= (rd_ptr == last) ? '0 : rd_ptr + pa'(1);
      if (enq & ~deq)      count <= count + cw'(1);
      else if (deq & ~enq) count <= count - cw'(1);
    end
  end
endmodule

module spi_adapter_mux #(
  parameter  int nbits       = 34,
  parameter  int num_entries = 2,
  parameter  int num_chans   = 4,
  localparam int pw          = nbits - 2,
  localparam int aw          = $clog2(num_chans),
  localparam int dw          = pw - aw
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_en,
  input  logic                    push_msg_val_wrt,
  input  logic                    push_msg_val_rd,
  input  logic [pw-1:0]           push_msg_data,
  input  logic                    pull_en,
  output logic                    pull_msg_val,
  output logic                    pull_msg_spc,
  output logic [pw-1:0]           pull_msg_data,
  input  logic [num_chans*dw-1:0] recv_msg,
  input  logic [num_chans-1:0]    recv_val,
  output logic [num_chans-1:0]    recv_rdy,
  output logic [num_chans*dw-1:0] send_msg,
  output logic [num_chans-1:0]    send_val,
  input  logic [num_chans-1:0]    send_rdy,
  output logic                    ovf_err
);
  localparam int cw = $clog2(num_entries + 1);
  localparam logic [cw-1:0] cap = cw'(num_entries);

  logic [aw-1:0]        ch;
  logic [dw-1:0]        wdat;
  logic                 wr_req;
  logic                 rd_req;
  logic                 pull_take;
  logic                 rd_pend;
  logic [aw-1:0]        rd_chan;
  logic [num_chans-1:0] mc_wr;
  logic [num_chans-1:0] mc_rdy;
  logic [num_chans-1:0] cm_rdy;
  logic [num_chans-1:0] cm_val;
  logic [num_chans-1:0] cm_take;
  logic [num_chans-1:0] chan_spc;
  logic [cw-1:0]        mc_cnt  [num_chans];
  logic [cw-1:0]        cm_cnt  [num_chans];
  logic [dw-1:0]        cm_head [num_chans];

  assign ch     = push_msg_data[pw-1:dw];
  assign wdat   = push_msg_data[dw-1:0];
  assign wr_req = push_en & push_msg_val_wrt;
  assign rd_req = push_en & push_msg_val_rd;

  assign pull_take     = pull_en & rd_pend & cm_val[rd_chan];
  assign pull_msg_val  = pull_take;
  assign pull_msg_data = pull_take ? {rd_chan, cm_head[rd_chan]} : '0;
  assign pull_msg_spc  = &chan_spc;
  assign recv_rdy      = cm_rdy & {num_chans{~reset}};

  for (genvar c = 0; c < num_chans; c++) begin : g_chan
    assign mc_wr[c]   = wr_req & (ch == aw'(c));
    assign mc_rdy[c]  = mc_cnt[c] < cap;
    assign cm_rdy[c]  = cm_cnt[c] < cap;
    assign cm_take[c] = pull_take & (rd_chan == aw'(c));
    // Space means one free slot left after this cycle's accepted write.
    assign chan_spc[c] = (mc_cnt[c] + cw'(mc_wr[c] & mc_rdy[c])) < cap;

    spi_adapter_mux_fifo #(.width(dw), .depth(num_entries)) u_mc (
      .clk     (clk),
      .reset   (reset),
      .enq_val (mc_wr[c]),
      .enq_msg (wdat),
      .deq_val (send_val[c]),
      .deq_msg (send_msg[c*dw +: dw]),
      .deq_rdy (send_rdy[c]),
      .count   (mc_cnt[c])
    );

    spi_adapter_mux_fifo #(.width(dw), .depth(num_entries)) u_cm (
      .clk     (clk),
      .reset   (reset),
      .enq_val (recv_val[c] & cm_rdy[c]),
      .enq_msg (recv_msg[c*dw +: dw]),
      .deq_val (cm_val[c]),
      .deq_msg (cm_head[c]),
      .deq_rdy (cm_take[c]),
      .count   (cm_cnt[c])
    );
  end

  // A fresh read request outranks the consume of the previous one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_chan <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_req & ~mc_rdy[ch]) ovf_err <= 1'b1;
      if (rd_req) begin
        rd_pend <= 1'b1;
        rd_chan <= ch;
      end else if (pull_take) begin
        rd_pend <= 1'b0;
      end
    end
  end
endmodule
